// File: rtl/brightness_pkg.sv
// Shared types, default geometry and pixel saturation for the brightness array.
// The loader and result_writer both import this so their address spaces agree.
package brightness_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } writer_state_t;

  localparam int DEFAULT_RAM_ADDR_WIDTH = 6;
  localparam int DEFAULT_RAM_DATA_WIDTH = 8;
  localparam int DEFAULT_PE_DATA_WIDTH  = 16;
  localparam int DEFAULT_DEPTH          = 4;

  // Clamp a signed PE result into [0, 2**out_width-1]; out_width must be below 31.
  function automatic logic [31:0] saturate(input logic signed [31:0] value,
                                           input int                 out_width);
    logic signed [31:0] max_val;
    max_val = (32'sd1 <<< out_width) - 32'sd1;
    if (value < 0)            return '0;
    else if (value > max_val) return $unsigned(max_val);
    else                      return $unsigned(value);
  endfunction

endpackage

// File: rtl/result_writer_if.sv
// Block input handshake and output RAM write port of result_writer.
// slave is the writer side, master is the upstream array / RAM side.
interface result_writer_if
  import brightness_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH,
  parameter int RAM_DATA_WIDTH = DEFAULT_RAM_DATA_WIDTH,
  parameter int PE_DATA_WIDTH  = DEFAULT_PE_DATA_WIDTH,
  parameter int DEPTH          = DEFAULT_DEPTH
);

  logic                            start;
  logic [PE_DATA_WIDTH*DEPTH-1:0]  data_in;
  logic                            data_valid;
  logic                            in_ready;
  logic [RAM_ADDR_WIDTH-1:0]       ram_address;
  logic [RAM_DATA_WIDTH-1:0]       ram_wdata;
  logic                            ram_we;
  logic                            done;

  modport master (
    output start, data_in, data_valid,
    input  in_ready, ram_address, ram_wdata, ram_we, done
  );

  modport slave (
    input  start, data_in, data_valid,
    output in_ready, ram_address, ram_wdata, ram_we, done
  );

endinterface

// File: rtl/block_fifo.sv
// Two-entry block buffer between the systolic array and the lane serializer.
// flush empties it in one edge and takes priority over push and pop.
module block_fifo #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; count alone marks which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/result_writer.sv
// Serializes buffered PE result blocks into saturated pixels written at
// sequential output-RAM addresses; one start pulse covers one frame.
module result_writer
  import brightness_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH,
  parameter int RAM_DATA_WIDTH = DEFAULT_RAM_DATA_WIDTH,
  parameter int PE_DATA_WIDTH  = DEFAULT_PE_DATA_WIDTH,
  parameter int DEPTH          = DEFAULT_DEPTH
) (
  input logic            clk,
  input logic            reset,
  result_writer_if.slave bus
);

  localparam int BLOCK_WIDTH = PE_DATA_WIDTH * DEPTH;
  localparam int LANE_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  writer_state_t state_q, state_d;

  logic [RAM_ADDR_WIDTH-1:0]      ptr_q;
  logic [LANE_WIDTH-1:0]          lane_q;
  logic [BLOCK_WIDTH-1:0]         head_data;
  logic [1:0]                     count;
  logic                           in_ready;
  logic                           push, pop, flush, do_write, last_lane;
  logic signed [PE_DATA_WIDTH-1:0] lane_val;
  logic [RAM_DATA_WIDTH-1:0]      sat_val;

  logic [RAM_ADDR_WIDTH-1:0]      ram_address_q;
  logic [RAM_DATA_WIDTH-1:0]      ram_wdata_q;
  logic                           ram_we_q;
  logic                           done_q;

  // Ready depends only on state and occupancy, never on data_valid.
  assign in_ready  = (state_q == WRITE) && (count < 2'd2);
  assign push      = bus.data_valid && in_ready;
  assign last_lane = (lane_q == LANE_WIDTH'(DEPTH - 1));
  assign lane_val  = head_data[lane_q*PE_DATA_WIDTH +: PE_DATA_WIDTH];
  assign sat_val   = RAM_DATA_WIDTH'(saturate(32'(lane_val), RAM_DATA_WIDTH));

  block_fifo #(.WIDTH(BLOCK_WIDTH)) u_block_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (bus.data_in),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    flush    = 1'b0;
    pop      = 1'b0;
    do_write = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = WRITE;
          flush   = 1'b1;
        end
      end
      WRITE: begin
        if (count != 2'd0) begin
          do_write = 1'b1;
          pop      = last_lane;
          if (ptr_q == '1) begin
            state_d = DONE;
            flush   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q         <= '0;
      lane_q        <= '0;
      ram_address_q <= '0;
      ram_wdata_q   <= '0;
      ram_we_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      ram_we_q <= do_write;
      done_q   <= (state_q == DONE) && !bus.start;
      if (do_write) begin
        ram_address_q <= ptr_q;
        ram_wdata_q   <= sat_val;
        ptr_q         <= ptr_q + 1'b1;
        lane_q        <= last_lane ? '0 : lane_q + 1'b1;
      end else if (state_q != WRITE) begin
        ram_address_q <= '0;
      end
      // Entering a pass (or finishing one) always restarts at pixel 0, lane 0.
      if (flush) begin
        ptr_q  <= '0;
        lane_q <= '0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.done        = done_q;

endmodule
